// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with byte-enable writes, optional zero register,
// write-to-read bypass and a post-reset clear sweep that gates the ready flag.
module regfile_multiport #(
  parameter int word_length    = 32,
  parameter int num_registers  = 32,
  parameter int address_width  = 5,
  parameter int num_read_ports = 2,
  parameter int zero_register  = 1,
  parameter int bypass_enable  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  output logic                                    ready,
  input  logic [num_read_ports*address_width-1:0] read_address,
  output logic [num_read_ports*word_length-1:0]   data_out,
  input  logic                                    write_enable,
  input  logic [address_width-1:0]                write_address,
  input  logic [word_length/8-1:0]                byte_enable,
  input  logic [word_length-1:0]                  data_in
);

  localparam int num_bytes = word_length / 8;
  localparam logic [address_width:0]   num_regs_c   = (address_width + 1)'(num_registers);
  localparam logic [address_width-1:0] last_index_c = address_width'(num_registers - 1);
  localparam logic [address_width-1:0] zero_addr_c  = {address_width{1'b0}};
  localparam logic [address_width-1:0] one_addr_c   = address_width'(1);
  localparam logic [word_length-1:0]   zero_word_c  = {word_length{1'b0}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [address_width-1:0] clear_cnt_r;
  logic [address_width-1:0] clear_cnt_next_s;
  logic                     ready_r;
  logic                     ready_next_s;
  logic                     wr_legal_s;
  logic [word_length-1:0]   mem_r [num_registers];

  // Enabled bytes come from new_word, the rest keep old_word.
  function automatic logic [word_length-1:0] merge_bytes(
    input logic [word_length-1:0] old_word,
    input logic [word_length-1:0] new_word,
    input logic [num_bytes-1:0]   be
  );
    logic [word_length-1:0] merged;
    merged = old_word;
    for (int b = 0; b < num_bytes; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

  // An address is live when it is in range and not the hardwired zero entry.
  function automatic logic addr_live(input logic [address_width-1:0] addr);
    logic in_range;
    logic is_zero_reg;
    in_range    = ({1'b0, addr} < num_regs_c);
    is_zero_reg = (zero_register != 32'sd0) && (addr == zero_addr_c);
    return in_range && !is_zero_reg;
  endfunction

  assign wr_legal_s = ready_r && write_enable && addr_live(write_address);
  assign ready      = ready_r;

  // Sweep/run state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CLEAR;
      clear_cnt_r <= zero_addr_c;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      clear_cnt_r <= clear_cnt_next_s;
      ready_r     <= ready_next_s;
    end
  end

  // Sweep sequencing: the last entry is cleared on the same edge that enters RUN.
  always_comb begin
    state_next_s     = state_r;
    clear_cnt_next_s = clear_cnt_r;
    ready_next_s     = ready_r;
    case (state_r)
      ST_CLEAR: begin
        if (clear_cnt_r == last_index_c) begin
          state_next_s = ST_RUN;
          ready_next_s = 1'b1;
        end else begin
          clear_cnt_next_s = clear_cnt_r + one_addr_c;
          ready_next_s     = 1'b0;
        end
      end
      ST_RUN: begin
        ready_next_s = 1'b1;
      end
      default: begin
        state_next_s     = ST_CLEAR;
        clear_cnt_next_s = zero_addr_c;
        ready_next_s     = 1'b0;
      end
    endcase
  end

  // Storage: no reset here, contents are only ever zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clear_cnt_r] <= zero_word_c;
    end else if (wr_legal_s) begin
      mem_r[write_address] <= merge_bytes(mem_r[write_address], data_in, byte_enable);
    end
  end

  for (genvar p = 0; p < num_read_ports; p++) begin : g_read
    logic [address_width-1:0] ra_s;
    logic [word_length-1:0]   word_s;

    assign ra_s = read_address[p*address_width +: address_width];

    // Combinational read with optional same-cycle forwarding of a legal write.
    always_comb begin
      word_s = zero_word_c;
      if (ready_r && addr_live(ra_s)) begin
        if ((bypass_enable != 32'sd0) && wr_legal_s && (ra_s == write_address)) begin
          word_s = merge_bytes(mem_r[ra_s], data_in, byte_enable);
        end else begin
          word_s = mem_r[ra_s];
        end
      end else begin
        word_s = zero_word_c;
      end
    end

    assign data_out[p*word_length +: word_length] = word_s;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: three configurations (bypass, no bypass, 24 entries) share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  wa;
  logic [3:0]  be;
  logic [31:0] din;
  logic [4:0]  ra0, ra1;
  logic [9:0]  ra_bus;
  logic        ready_a, ready_b, ready_c;
  logic [63:0] dout_a, dout_b, dout_c;

  logic [31:0] mem_ab [32];
  logic [31:0] mem_c  [24];
  int          edges;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  assign ra_bus = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_multiport #(.bypass_enable(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .ready(ready_a), .read_address(ra_bus), .data_out(dout_a),
    .write_enable(we), .write_address(wa), .byte_enable(be), .data_in(din));

  regfile_multiport #(.bypass_enable(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ready(ready_b), .read_address(ra_bus), .data_out(dout_b),
    .write_enable(we), .write_address(wa), .byte_enable(be), .data_in(din));

  regfile_multiport #(.num_registers(24)) dut_c (
    .clk(clk), .reset_n(reset_n), .ready(ready_c), .read_address(ra_bus), .data_out(dout_c),
    .write_enable(we), .write_address(wa), .byte_enable(be), .data_in(din));

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // cfg 0: 32 entries + bypass, 1: 32 entries no bypass, 2: 24 entries + bypass
  function automatic logic [31:0] exp_read(input int cfg, input logic [4:0] addr);
    int          n;
    logic [31:0] m;
    n = (cfg == 2) ? 24 : 32;
    if (edges < n) return 32'h0;
    if (int'(addr) >= n) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    m = (cfg == 2) ? mem_c[addr] : mem_ab[addr];
    if (cfg != 1 && we && wa == addr) m = merge(m, din, be);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a.ready", {31'h0, ready_a}, (edges >= 32) ? 32'h1 : 32'h0);
    check("b.ready", {31'h0, ready_b}, (edges >= 32) ? 32'h1 : 32'h0);
    check("c.ready", {31'h0, ready_c}, (edges >= 24) ? 32'h1 : 32'h0);
    check("a.port0", dout_a[31:0],  exp_read(0, ra0));
    check("a.port1", dout_a[63:32], exp_read(0, ra1));
    check("b.port0", dout_b[31:0],  exp_read(1, ra0));
    check("b.port1", dout_b[63:32], exp_read(1, ra1));
    check("c.port0", dout_c[31:0],  exp_read(2, ra0));
    check("c.port1", dout_c[63:32], exp_read(2, ra1));
  endtask

  task automatic drive(input logic we_i, input logic [4:0] wa_i, input logic [3:0] be_i,
                       input logic [31:0] din_i, input logic [4:0] ra0_i, input logic [4:0] ra1_i);
    @(negedge clk);
    reset_n = 1'b1;
    we  = we_i;
    wa  = wa_i;
    be  = be_i;
    din = din_i;
    ra0 = ra0_i;
    ra1 = ra1_i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      if (edges >= 32 && we && wa != 5'd0) mem_ab[wa] = merge(mem_ab[wa], din, be);
      if (edges >= 24 && we && wa != 5'd0 && wa < 5'd24) mem_c[wa] = merge(mem_c[wa], din, be);
      edges++;
    end
  endtask

  task automatic step(input logic we_i, input logic [4:0] wa_i, input logic [3:0] be_i,
                      input logic [31:0] din_i, input logic [4:0] ra0_i, input logic [4:0] ra1_i);
    drive(we_i, wa_i, be_i, din_i, ra0_i, ra1_i);
    check_all();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    we      = 1'b0;
    edges   = 0;
    for (int i = 0; i < 32; i++) mem_ab[i] = 32'h0;
    for (int i = 0; i < 24; i++) mem_c[i] = 32'h0;
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all();
    @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b1;
    we = 1'b0; wa = 5'd0; be = 4'h0; din = 32'h0; ra0 = 5'd0; ra1 = 5'd0;
    edges = 0;

    do_reset();
    // Sweep window: random writes must all be dropped.
    for (int i = 0; i < 32; i++)
      step(1'b1, 5'($urandom), 4'hF, $urandom, 5'($urandom), 5'($urandom));
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd1, 5'd2);
    check("sweep.ready_a", {31'h0, ready_a}, 32'h1);
    check_all();
    tick();
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 4'h0, 32'h0, 5'(i), 5'(31 - i));

    // Full write then read on both ports.
    step(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5);
    check_all();
    check("r5.port0", dout_a[31:0], 32'hDEADBEEF);
    check("r5.port1", dout_a[63:32], 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd6, 5'd6);
    check_all();
    check("r6.zero", dout_a[31:0], 32'h0);
    tick();

    // Byte mask.
    step(1'b1, 5'd7, 4'hF, 32'h11223344, 5'd0, 5'd0);
    step(1'b1, 5'd7, 4'b0101, 32'hAABBCCDD, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd7);
    check_all();
    check("r7.mask", dout_a[31:0], 32'h11BB33DD);
    tick();

    // Zero register and out-of-range on the 24-entry file.
    step(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
    check_all();
    check("r0.zero", dout_a[31:0], 32'h0);
    tick();
    step(1'b1, 5'd30, 4'hF, 32'hCAFEF00D, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd30, 5'd30);
    check_all();
    check("c.r30", dout_c[31:0], 32'h0);
    check("a.r30", dout_a[31:0], 32'hCAFEF00D);
    tick();

    // Bypass versus no bypass.
    step(1'b1, 5'd9, 4'hF, 32'h0, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 4'b0011, 32'h12345678, 5'd9, 5'd9);
    check_all();
    check("bypass.a", dout_a[31:0], 32'h00005678);
    check("bypass.b", dout_b[31:0], 32'h00000000);
    tick();
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd9);
    check_all();
    check("after_edge.b", dout_b[31:0], 32'h00005678);
    tick();

    // Random traffic, biased so reads often hit the write target.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] w_addr;
      w_addr = 5'($urandom);
      step(1'($urandom), w_addr, 4'($urandom), $urandom,
           ($urandom_range(0, 2) == 0) ? w_addr : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom));
    end

    // Reset from RUN, interrupt the sweep at cycle 10, then a full sweep again.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) step(1'b1, 5'd12, 4'hF, 32'hA5A5A5A5, 5'd12, 5'd3);
      else        step(1'b0, 5'd0, 4'h0, 32'h0, 5'($urandom), 5'($urandom));
    end
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 4'h0, 32'h0, 5'($urandom), 5'($urandom));
    drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd12, 5'd12);
    check_all();
    check("midsweep.ready_a", {31'h0, ready_a}, 32'h1);
    check("midsweep.r12", dout_a[31:0], 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the datapath register file. It is clocked, uses byte-enable writes, and has N packed read ports. It supports a hardwired zero register, write-to-read bypass, and a post-reset sequential clear sweep with a ready flag. It sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
word_length, 32, data width in bits; must be a multiple of 8.
num_registers, 32, number of entries; 2..2**address_width.
address_width, 5, width of every address field.
num_read_ports, 2, number of independent read ports; minimum 1.
zero_register, 1, 1 = entry 0 always reads 0 and ignores writes.
bypass_enable, 1, 1 = a same-cycle write is forwarded to matching reads.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
ready  output  1  high when the clear sweep is done and the file is usable.
read_address  input  num_read_ports*address_width  packed; port p uses bits [p*address_width +: address_width].
data_out  output  num_read_ports*word_length  packed; port p uses bits [p*word_length +: word_length].
write_enable  input  1  write request, sampled on the rising edge of clk.
write_address  input  address_width  write target.
byte_enable  input  word_length/8  per-byte write mask; bit b covers bits [8b+7:8b].
data_in  input  word_length  write data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ready = 0, clear counter = 0, FSM enters CLEAR.
  - Storage contents are not touched asynchronously.
- FSM states: CLEAR and RUN.
- CLEAR:
  - On each clk edge, writes 0 to entry[clear counter], then increments the counter.
  - When the counter reaches num_registers-1, that entry is cleared on that edge, the FSM moves to RUN and ready goes to 1.
  - The sweep takes exactly num_registers cycles after reset_n deasserts.
- RUN: ready stays 1 until the next reset.
- Reset asserted mid-sweep or mid-RUN: the counter restarts at 0 and a full sweep runs again.
- Write (RUN only), on the rising edge of clk when write_enable=1:
  - Each byte with byte_enable[b]=1 is updated from data_in.
  - Bytes with byte_enable[b]=0 keep their old value.
  - byte_enable all zero is a no-op.
- Write suppression:
  - In CLEAR, write_enable is ignored entirely; the write is dropped, not queued.
  - Writes with write_address >= num_registers are dropped.
  - Writes to address 0 are dropped when zero_register=1.
- Read (combinational from the stored array; zero latency):
  - data_out port p = entry[read_address p].
  - Returns 0 if address >= num_registers.
  - Returns 0 if address = 0 and zero_register=1.
  - Returns 0 for all ports while ready=0.
- Bypass (bypass_enable=1, ready=1, write_enable=1, address matches write_address, write legal):
  - Output is the merged word: enabled bytes from data_in, other bytes from the stored entry.
  - Bypass never overrides the zero-register or out-of-range rules.
- With bypass_enable=0, reads show the old value until the clock edge, then the new value.
- Multiple read ports may address the same entry; each returns the identical value.
- There are no write-write conflicts (single write port).
- No X propagates to data_out after reset_n has been seen low at least once.

Test Plan:
- Clear sweep (num_registers=32):
  - Pulse reset_n low, release -> ready=0 for exactly 32 clk edges, then 1.
  - Every address then reads 0x00000000.
- Full write:
  - Write 0xDEADBEEF to r5 with byte_enable=4'hF.
  - Next cycle, read port 0 at r5 and port 1 at r5 -> both 0xDEADBEEF.
  - A read of r6 returns 0.
- Byte mask:
  - r7 = 0x11223344; write 0xAABBCCDD with byte_enable=4'b0101 -> r7 reads 0x11BB33DD.
- Zero register and out-of-range:
  - Write 0xFFFFFFFF to r0 -> reads 0.
  - With num_registers=24, write address 30 -> dropped, and a read of address 30 returns 0.
- Bypass:
  - r9 = 0x00000000; in the same cycle, write r9 = 0x12345678 (byte_enable=4'b0011) and read r9.
  - bypass_enable=1 -> 0x00005678 combinationally.
  - bypass_enable=0 -> 0x00000000, then 0x00005678 after the edge.
- Reset mid-sweep:
  - Assert reset_n at sweep cycle 10, release -> ready rises 32 cycles after release.
  - A write attempted during the sweep is lost (reads 0 afterwards).
